gemm_tile_engine: RTL and testbench
===================================

// Module: gemm_tile_engine
// PURPOSE
// - Parametrised ROWSxCOLS GEMM tile engine; next generation of the 16x16 weight-stationary array.
// - Computes C = P + A*W over a runtime K depth and streams C out one column per handshake.
// - Adds signed/unsigned mode, accumulate-in-place and valid/ready on activation and result streams.
// - Sits between the GEMM controller (weights, activations, bias/psum) and the writeback buffer.
// PARAMETERS
// - DATA_WIDTH  8   activation/weight element width
// - ACC_WIDTH   32  accumulator and result element width
// - ROWS        16  output rows (activation vector length)
// - COLS        16  output columns (weight row length)
// - K_MAX       16  weight rows stored; maximum reduction depth
// PORTS
// - clk            in   1                clock, posedge only
// - rst            in   1                asynchronous, active-high reset
// - w_valid        in   1                weight row write strobe
// - w_ready        out  1                1 only in IDLE
// - w_row          in   $clog2(K_MAX)    weight row index k
// - w_data         in   COLS*DATA_WIDTH  W[k][0..COLS-1], element j at [j*DATA_WIDTH +: DATA_WIDTH]
// - cfg_k_len      in   $clog2(K_MAX+1)  reduction depth, sampled on start
// - cfg_signed     in   1                1: signed operands, 0: unsigned; sampled on start
// - cfg_accumulate in   1                1: keep accumulators, 0: init from psum_in; sampled on start
// - psum_in        in   ROWS*ACC_WIDTH   per-row initial value, broadcast across columns
// - start          in   1                launch a tile (honoured in IDLE only)
// - a_valid        in   1                activation beat valid
// - a_ready        out  1                1 only in COMPUTE
// - a_data         in   ROWS*DATA_WIDTH  A[0..ROWS-1][k] for current k (unskewed)
// - out_valid      out  1                result column valid
// - out_ready      in   1                downstream accepts column
// - out_col        out  $clog2(COLS)     index of column on out_data
// - out_data       out  ROWS*ACC_WIDTH   C[0..ROWS-1][out_col]
// - out_last       out  1                out_valid and out_col==COLS-1
// - busy           out  1                state != IDLE
// - done           out  1                one-cycle pulse after final column accepted
// - cfg_err        out  1                one-cycle pulse: start with cfg_k_len==0 or >K_MAX
// - sat_flag       out  1                sticky saturation indicator (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state IDLE; all weights, accumulators, counters 0; every output 0 except w_ready=1.
// - States: IDLE -> COMPUTE -> OUTPUT -> IDLE.
// - IDLE: w_valid writes W[w_row] next edge; w_row>=K_MAX ignored. start with bad cfg_k_len -> cfg_err, stay IDLE.
// - Valid start: latch cfg; if !cfg_accumulate, accum[i][j]<=psum_in[i]; clear sat_flag; k_cnt<=0; -> COMPUTE.
// - Same-cycle w_valid and start: weight write lands first, before any COMPUTE beat.
// - COMPUTE: a_ready=1; per a_valid beat accum[i][j] += ext(a[i])*ext(W[k_cnt][j]); k_cnt++.
// - Beat k_cnt==k_len-1 -> OUTPUT next cycle; a_valid gaps stall without timeout.
// - Product 2*DATA_WIDTH bits, sign/zero-extended per cfg_signed to ACC_WIDTH; add wraps mod 2^ACC_WIDTH.
// - OUTPUT: out_valid=1 from first cycle, out_col starts 0; out_data/out_col stable while !out_ready.
// - out_valid&out_ready advances column; on out_last accept -> IDLE, done=1 next cycle.
// - Accumulators retain values after OUTPUT so next cfg_accumulate=1 tile continues them.
// - start, w_valid ignored while busy; a_valid ignored outside COMPUTE.
// - rst asserted mid-tile: immediate abort to reset state; no done pulse, weights lost.
// CONFIGURATION
// - Macro GEMM_ACC_SAT_EN.
// - Defined: each add saturates to signed ACC_WIDTH range (unsigned mode: [0, 2^ACC_WIDTH-1]).
// - Defined: any clamp sets sat_flag, sticky until next valid start or rst.
// - Undefined: wrapping add as above; sat_flag tied 0; no saturation logic synthesised.
// TESTING
// - Identity W (k_len=16), signed A[i][k]=i-k, psum=0 -> out col j row i = i-j; 16 beats, done once.
// - cfg_signed=0, A=all 8'hFF, W=all 8'hFF, k_len=16 -> every element 16*65025=1040400.
// - cfg_accumulate=1 repeat of previous tile -> every element 2080800; psum_in ignored.
// - out_ready toggled 1010..., a_valid gaps every 3rd cycle -> data identical to unstalled run, stable on stall.
// - start with cfg_k_len=0 -> cfg_err 1 cycle, busy stays 0; rst mid-OUTPUT -> out_valid 0, no done.
// - GEMM_ACC_SAT_EN, ACC_WIDTH=16, signed A=W=-128, k_len=4 -> 32767, sat_flag=1; undefined build -> wraps to 0.

Source files
------------

// File: rtl/gemm_tile_engine.sv
// gemm_tile_engine: ROWS x COLS weight-stationary GEMM tile engine.
// Computes C = P + A*W over a runtime reduction depth and streams C out one
// column per handshake.
// Optional feature: define GEMM_ACC_SAT_EN to make every accumulator add
// saturate and to drive the sticky sat_flag; without it, adds wrap and
// sat_flag is tied 0.
//
// Handshake rule for every stream (a_*, out_*): a transfer happens on a rising
// clk edge where valid and ready are both 1; the sender keeps valid and data
// stable until that edge, and ready never depends combinationally on valid.
module gemm_tile_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ROWS       = 16,
  parameter int COLS       = 16,
  parameter int K_MAX      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [$clog2(K_MAX)-1:0]     w_row,
  input  logic [COLS*DATA_WIDTH-1:0]   w_data,
  input  logic [$clog2(K_MAX+1)-1:0]   cfg_k_len,
  input  logic                         cfg_signed,
  input  logic                         cfg_accumulate,
  input  logic [ROWS*ACC_WIDTH-1:0]    psum_in,
  input  logic                         start,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]   a_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(COLS)-1:0]      out_col,
  output logic [ROWS*ACC_WIDTH-1:0]    out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  output logic                         sat_flag,
  output logic [1:0]                   dbg_state
);

  localparam int KW  = $clog2(K_MAX);
  localparam int KLW = $clog2(K_MAX+1);
  localparam int CW  = $clog2(COLS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_OUTPUT  = 2'd2;

  logic [1:0]            state_q;
  logic [DATA_WIDTH-1:0] w_mem   [K_MAX][COLS];
  logic [ACC_WIDTH-1:0]  acc_q   [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  acc_nxt [ROWS][COLS];
  logic [KW-1:0]         k_cnt_q;
  logic [KLW-1:0]        k_len_q;
  logic                  signed_q;
  logic [CW-1:0]         col_q;
  logic                  done_q;
  logic                  cfg_err_q;
  logic                  sat_hit;

  logic start_ok, start_go, a_fire, last_beat, last_col;

  // Operands are widened to ACC_WIDTH first, so the low ACC_WIDTH bits of the
  // product equal the sign/zero-extended 2*DATA_WIDTH product.
  function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] w,
                                                   input logic sgn);
    logic [ACC_WIDTH-1:0] ax;
    logic [ACC_WIDTH-1:0] wx;
    ax = {{(ACC_WIDTH-DATA_WIDTH){sgn & a[DATA_WIDTH-1]}}, a};
    wx = {{(ACC_WIDTH-DATA_WIDTH){sgn & w[DATA_WIDTH-1]}}, w};
    return ax * wx;
  endfunction

  assign start_ok  = (cfg_k_len != '0) && (int'(cfg_k_len) <= K_MAX);
  assign start_go  = (state_q == S_IDLE) && start && start_ok;
  assign a_fire    = (state_q == S_COMPUTE) && a_valid;
  assign last_beat = (int'(k_cnt_q) == int'(k_len_q) - 1);
  assign last_col  = (int'(col_q) == COLS - 1);

  assign w_ready   = (state_q == S_IDLE);
  assign a_ready   = (state_q == S_COMPUTE);
  assign out_valid = (state_q == S_OUTPUT);
  assign out_col   = col_q;
  assign out_last  = out_valid && last_col;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign dbg_state = state_q;

  // Weight rows are writable only while idle; out-of-range rows are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < K_MAX; k++)
        for (int j = 0; j < COLS; j++)
          w_mem[k][j] <= '0;
    end else if ((state_q == S_IDLE) && w_valid && (int'(w_row) < K_MAX)) begin
      for (int j = 0; j < COLS; j++)
        w_mem[w_row][j] <= w_data[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next accumulator values for the current activation beat (wrap or clamp).
  always_comb begin
    logic [ACC_WIDTH-1:0] prod;
`ifdef GEMM_ACC_SAT_EN
    logic [ACC_WIDTH:0]   sum;
`endif
    sat_hit = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        prod = mul_ext(a_data[i*DATA_WIDTH +: DATA_WIDTH], w_mem[k_cnt_q][j], signed_q);
`ifdef GEMM_ACC_SAT_EN
        sum = {signed_q & acc_q[i][j][ACC_WIDTH-1], acc_q[i][j]} +
              {signed_q & prod[ACC_WIDTH-1], prod};
        if (signed_q && (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])) begin
          acc_nxt[i][j] = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
          sat_hit = 1'b1;
        end else if (!signed_q && sum[ACC_WIDTH]) begin
          acc_nxt[i][j] = {ACC_WIDTH{1'b1}};
          sat_hit = 1'b1;
        end else begin
          acc_nxt[i][j] = sum[ACC_WIDTH-1:0];
        end
`else
        acc_nxt[i][j] = acc_q[i][j] + prod;
`endif
      end
    end
  end

  // Accumulators: seeded from psum_in on a fresh start, updated per beat,
  // otherwise held so an accumulate-mode tile can continue them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          acc_q[i][j] <= '0;
    end else if (start_go && !cfg_accumulate) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          acc_q[i][j] <= psum_in[i*ACC_WIDTH +: ACC_WIDTH];
    end else if (a_fire) begin
      acc_q <= acc_nxt;
    end
  end

  // Tile sequencing FSM: IDLE -> COMPUTE -> OUTPUT -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_cnt_q   <= '0;
      k_len_q   <= '0;
      signed_q  <= 1'b0;
      col_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              k_len_q  <= cfg_k_len;
              signed_q <= cfg_signed;
              k_cnt_q  <= '0;
              col_q    <= '0;
              state_q  <= S_COMPUTE;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (a_fire) begin
            if (last_beat) begin
              col_q   <= '0;
              state_q <= S_OUTPUT;
            end else begin
              k_cnt_q <= k_cnt_q + 1'b1;
            end
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            if (last_col) begin
              col_q   <= '0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef GEMM_ACC_SAT_EN
  logic sat_q;
  // Sticky clamp indicator, cleared by each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  sat_q <= 1'b0;
    else if (start_go)        sat_q <= 1'b0;
    else if (a_fire && sat_hit) sat_q <= 1'b1;
  end
  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

  // Result column view: row i of the currently selected column.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < ROWS; i++)
      out_data[i*ACC_WIDTH +: ACC_WIDTH] = acc_q[i][col_q];
  end

endmodule

// File: tb/tb_gemm_tile_engine.sv
// tb_gemm_tile_engine: directed tiles with closed-form expected columns kept
// in a scoreboard queue; a monitor compares every presented result column.
module tb_gemm_tile_engine;

  localparam int DW   = 8;
  localparam int AW   = 32;
  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int KMAX = 16;
  localparam int CW   = $clog2(COLS);
  localparam int W    = ROWS*AW + CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   w_valid = 0;
  logic                   w_ready;
  logic [$clog2(KMAX)-1:0]   w_row = '0;
  logic [COLS*DW-1:0]     w_data = '0;
  logic [$clog2(KMAX+1)-1:0] cfg_k_len = '0;
  logic                   cfg_signed = 0;
  logic                   cfg_accumulate = 0;
  logic [ROWS*AW-1:0]     psum_in = '0;
  logic                   start = 0;
  logic                   a_valid = 0;
  logic                   a_ready;
  logic [ROWS*DW-1:0]     a_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1;
  logic [CW-1:0]          out_col;
  logic [ROWS*AW-1:0]     out_data;
  logic                   out_last;
  logic                   busy, done, cfg_err, sat_flag;
  logic [1:0]             dbg_state;

  gemm_tile_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(ROWS), .COLS(COLS), .K_MAX(KMAX)) dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row), .w_data(w_data),
    .cfg_k_len(cfg_k_len), .cfg_signed(cfg_signed), .cfg_accumulate(cfg_accumulate),
    .psum_in(psum_in), .start(start), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .cfg_err(cfg_err), .sat_flag(sat_flag),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cfg_err_cnt = 0;
  int busy_cnt = 0;
  int ready_mode = 0;  // 0: always ready, 1: toggle, 2: held low
  logic [W-1:0] exp_q[$];

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (done) done_cnt++;
    if (cfg_err) cfg_err_cnt++;
    if (busy) busy_cnt++;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        if (out_ready) begin
          checks++; errors++;
          $display("FAIL unexpected_col: got col %0d with empty queue", out_col);
        end
      end else begin
        e = exp_q[0];
        checks++;
        if ({out_data, out_col} !== e || out_last !== (int'(e[CW-1:0]) == COLS-1)) begin
          errors++;
          $display("FAIL col%0d%s: got %h last=%0b expected %h", e[CW-1:0],
                   out_ready ? "" : "_stall", {out_data, out_col}, out_last, e);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [COLS*DW-1:0] w_ident(input int k);
    logic [COLS*DW-1:0] r = '0;
    for (int j = 0; j < COLS; j++) r[j*DW +: DW] = (j == k) ? 8'd1 : 8'd0;
    return r;
  endfunction

  function automatic logic [ROWS*DW-1:0] a_ident(input int k);
    logic [ROWS*DW-1:0] r = '0;
    for (int i = 0; i < ROWS; i++) r[i*DW +: DW] = 8'(i - k);
    return r;
  endfunction

  task automatic load_w(input int k, input logic [COLS*DW-1:0] row);
    w_valid = 1; w_row = 4'(k); w_data = row;
    tick();
    w_valid = 0;
  endtask

  task automatic set_cfg(input int k_len, input bit sgn, input bit acc, input logic [AW-1:0] p);
    cfg_k_len = 5'(k_len); cfg_signed = sgn; cfg_accumulate = acc;
    for (int i = 0; i < ROWS; i++) psum_in[i*AW +: AW] = p;
  endtask

  task automatic start_tile();
    start = 1; tick(); start = 0;
  endtask

  task automatic feed(input logic [ROWS*DW-1:0] a, input bit gap);
    bit r = 0;
    if (gap) begin a_valid = 0; tick(); end
    a_valid = 1; a_data = a;
    for (int t = 0; t < 50 && !r; t++) begin
      @(negedge clk); r = a_ready;
      tick();
    end
    a_valid = 0;
    if (!r) chk("a_handshake_timeout", 0, 1);
  endtask

  task automatic push_ident();
    logic [W-1:0] e;
    for (int j = 0; j < COLS; j++) begin
      e = '0;
      for (int i = 0; i < ROWS; i++) e[CW + i*AW +: AW] = AW'(i - j);
      e[CW-1:0] = CW'(j);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_const(input logic [AW-1:0] v);
    logic [W-1:0] e;
    for (int j = 0; j < COLS; j++) begin
      e = '0;
      for (int i = 0; i < ROWS; i++) e[CW + i*AW +: AW] = v;
      e[CW-1:0] = CW'(j);
      exp_q.push_back(e);
    end
  endtask

  task automatic finish_tile(input string name, input int done_base);
    bit idle = 0;
    for (int t = 0; t < 400 && !idle; t++) begin
      @(negedge clk); idle = !busy;
    end
    if (!idle) chk({name, "_idle_timeout"}, 0, 1);
    tick(); tick();
    chk({name, "_done_once"}, done_cnt - done_base, 1);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    logic [AW-1:0] sat_exp_v;
    bit sat_exp_f;
    bit seen;
`ifdef GEMM_ACC_SAT_EN
    sat_exp_v = 32'h7FFF_FFFF; sat_exp_f = 1;
`else
    sat_exp_v = 32'h8000_0000; sat_exp_f = 0;
`endif
    tick(); tick();
    @(negedge clk);
    chk("rst_w_ready", w_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_out_data", out_data[63:0], 0);
    chk("rst_out_col", out_col, 0);
    rst = 0;
    tick();

    // Tile 1: identity W, signed A[i][k]=i-k; last row written with start.
    for (int k = 0; k < KMAX - 1; k++) load_w(k, w_ident(k));
    set_cfg(16, 1, 0, '0);
    push_ident();
    base = done_cnt;
    w_valid = 1; w_row = 4'(KMAX - 1); w_data = w_ident(KMAX - 1);
    start_tile();
    w_valid = 0;
    for (int k = 0; k < 16; k++) feed(a_ident(k), 0);
    finish_tile("ident", base);

    // Tile 2: unsigned all-ones bytes.
    for (int k = 0; k < KMAX; k++) load_w(k, {COLS{8'hFF}});
    set_cfg(16, 0, 0, '0);
    push_const(32'd1040400);
    base = done_cnt;
    start_tile();
    for (int k = 0; k < 16; k++) feed({ROWS{8'hFF}}, 0);
    finish_tile("unsigned", base);

    // Tile 3: accumulate in place; psum_in must be ignored.
    set_cfg(16, 0, 1, 32'h1234_5678);
    push_const(32'd2080800);
    base = done_cnt;
    start_tile();
    for (int k = 0; k < 16; k++) feed({ROWS{8'hFF}}, 0);
    finish_tile("accum", base);

    // Tile 4: identity again with output back-pressure and input gaps.
    for (int k = 0; k < KMAX; k++) load_w(k, w_ident(k));
    set_cfg(16, 1, 0, '0);
    push_ident();
    base = done_cnt;
    ready_mode = 1;
    start_tile();
    for (int k = 0; k < 16; k++) feed(a_ident(k), (k % 3) == 2);
    finish_tile("stall", base);
    ready_mode = 0;

    // Bad depths: k_len 0 and K_MAX+1.
    base = cfg_err_cnt; busy_cnt = 0;
    set_cfg(0, 1, 0, '0); start_tile(); tick(); tick();
    chk("cfg_err_k0", cfg_err_cnt - base, 1);
    set_cfg(17, 1, 0, '0); start_tile(); tick(); tick();
    chk("cfg_err_k17", cfg_err_cnt - base, 2);
    chk("cfg_err_busy", busy_cnt, 0);

    // Overflow tile: 0x7FFF0000 + 4*(-128*-128) crosses the signed max.
    for (int k = 0; k < 4; k++) load_w(k, {COLS{8'h80}});
    set_cfg(4, 1, 0, 32'h7FFF_0000);
    push_const(sat_exp_v);
    base = done_cnt;
    start_tile();
    for (int k = 0; k < 4; k++) feed({ROWS{8'h80}}, 0);
    finish_tile("sat", base);
    chk("sat_flag", sat_flag, sat_exp_f);

    // Reset while results are being presented.
    ready_mode = 2;
    set_cfg(1, 1, 0, '0);
    base = done_cnt;
    start_tile();
    chk("sat_flag_cleared", sat_flag, 0);
    feed({ROWS{8'h01}}, 0);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk); seen = out_valid;
    end
    chk("rst_mid_out_valid_seen", seen, 1);
    tick();
    rst = 1;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_data", out_data[63:0], 0);
    rst = 0;
    ready_mode = 0;
    for (int t = 0; t < 5; t++) tick();
    chk("abort_no_done", done_cnt - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
